mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one 4:1 one-bit mux between four requesters.
- Owns the mux select and registers the selected data bit.
- Requester i presents request `req[i]` and data `a[i]`. The block grants one requester at a time, drives `s`, and outputs `a[s]` on `y` with a valid flag.
- Sits between requesting sources and any single-bit shared sink.

Parameters:
- HOLD_MAX, 4: max consecutive grant cycles for one requester while another is waiting (timeout feature only); legal range 1..2^HOLD_W-1.
- HOLD_W, 3: width of the hold counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  4  request lines, bit i = requester i
- a  input  4  data bits, bit i = requester i's data
- gnt  output  4  registered one-hot grant, all zero when idle
- s  output  2  registered mux select = index of granted requester
- y  output  1  registered mux output
- valid  output  1  high when gnt is non-zero; y meaningful only when valid=1

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all outputs cleared at the next clk edge while rst=1.
  - gnt=0000, s=00, y=0, valid=0.
  - State=IDLE, hold_cnt=0, last pointer ptr=3, so requester 0 wins first.
  - Reset mid-grant drops the grant the same way; no state is retained.
- All decisions use req sampled at the clk edge.
- Outputs gnt, s, valid and y change only on the edge.
- Round-robin search: starts at (ptr+1) mod 4, picks the first index with req=1, wraps 3->0.
- State IDLE:
  - If req==0000: stay IDLE; gnt=0, valid=0, y=0, s holds its last value.
  - Else: go to GRANT at the next edge.
    - gnt=onehot(w), s=w, valid=1, y=a[w] (sampled that edge).
    - ptr=w, hold_cnt=1.
- State GRANT, current owner c=s, each edge:
  - Release (req[c]=0):
    - Other requests pending: hand over directly to the RR winner from c+1, with no idle bubble. hold_cnt=1.
    - No requests pending: go to IDLE; gnt=0, valid=0, y=0.
  - Keep (req[c]=1, no timeout rotation): gnt/s unchanged, y=a[c].
    - hold_cnt increments, saturating at 2^HOLD_W-1.
  - Timeout rotation: see Optional Feature.
- Latency:
  - Request in IDLE to grant: 1 cycle.
  - Data: y at edge t+1 equals a[s] sampled at edge t+1; one register stage, updated every cycle while granted.
- Simultaneous release of owner and arrival of new requests: the new requests are considered in the same edge's search.
- An owner that releases and re-requests in the same cycle is not possible (req is level); a 1-cycle drop is a release.
- gnt is always zero or one-hot; s always equals the index of the set gnt bit while valid=1.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined: in GRANT with req[c]=1, hold_cnt==HOLD_MAX and any other req bit set, the grant rotates at that edge.
  - Rotation goes to the RR winner starting at c+1; hold_cnt=1.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates.
- Not defined: the owner keeps the grant as long as its req stays high, regardless of hold_cnt; no forced rotation. hold_cnt logic may be removed.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, s=00, y=0, valid=0. After release, first grant is gnt=0001, s=00.
- Single requester: req=0100, a=0100 -> 1 cycle later gnt=0100, s=10, y=1, valid=1. Drop req -> next edge gnt=0000, valid=0, y=0.
- Direct handover: req=0011, owner 0 drops req[0] -> next edge gnt=0010, s=01, no idle cycle. Then req=0000 -> IDLE.
- Round-robin fairness: req=1111 held, each owner drops after 1 cycle and re-raises -> grant order 0,1,2,3,0; s=00,01,10,11,00; y tracks a[s] with a=1010.
- Timeout (MUX_ARB_TIMEOUT_EN, HOLD_MAX=4): req=1001 held, owner 0 -> gnt=0001 for exactly 4 cycles, then gnt=1000 for 4, then gnt=0001. Without the macro, gnt=0001 persists.
- Reset mid-grant: rst=1 during gnt=0100 -> next edge all outputs zero. With req=0100 still high after release, regrant gnt=0100 1 cycle after rst falls.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
// Optional forced rotation after HOLD_MAX cycles is enabled by `define MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] a,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       y,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Handshake: a requester holds req[i] high for as long as it wants the mux;
  // gnt/valid/y are registered and reflect req sampled at the previous edge.
  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic       rotate;
  logic       do_grant;
  logic       go_idle;

  // Returns {found, index}: first requester at or after p+1, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, ptr);
  end

`ifdef MUX_ARB_TIMEOUT_EN
  assign rotate = (state == GRANT) && req[s] &&
                  (hold_cnt == HOLD_W'(HOLD_MAX)) && (|(req & ~gnt));
`else
  assign rotate = 1'b0;
`endif

  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE: begin
        do_grant = pick_found;
        go_idle  = !pick_found;
      end
      GRANT: begin
        if (!req[s]) begin
          do_grant = pick_found;
          go_idle  = !pick_found;
        end else begin
          do_grant = rotate;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      s        <= 2'b00;
      y        <= 1'b0;
      valid    <= 1'b0;
      ptr      <= 2'd3;
      hold_cnt <= '0;
    end else if (do_grant) begin
      state    <= GRANT;
      gnt      <= 4'b0001 << pick_idx;
      s        <= pick_idx;
      y        <= a[pick_idx];
      valid    <= 1'b1;
      ptr      <= pick_idx;
      hold_cnt <= HOLD_W'(1);
    end else if (go_idle) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      y        <= 1'b0;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      // Owner keeps the mux: refresh data every cycle, saturate the hold count.
      y <= a[s];
      if (hold_cnt != {HOLD_W{1'b1}}) hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: hand-derived expectations queued per step,
// compared one cycle later against {gnt, s, y, valid}.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       valid;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mux4_rr_arbiter #(.HOLD_MAX(4), .HOLD_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .gnt(gnt), .s(s), .y(y), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, queue the expected outputs, check after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] av,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic ey, input logic ev, input string tag);
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    string      t;
    @(negedge clk);
    rst = r;
    req = rq;
    a   = av;
    exp_q.push_back({eg, es, ey, ev});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = {gnt, s, y, valid};
    tests_run++;
    assert (obs_v === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s observed gnt=%b s=%b y=%b valid=%b expected gnt=%b s=%b y=%b valid=%b",
             t, obs_v[7:4], obs_v[3:2], obs_v[1], obs_v[0],
             exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    a   = 4'b0000;

    // Reset with all requests asserted
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset_0");
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset_1");
    step(0, 4'b1111, 4'b0000, 4'b0001, 2'b00, 0, 1, "first_grant");
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "idle_after_first");

    // Single requester, y follows a[s] each cycle
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "single_grant");
    step(0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 0, 1, "single_data_track");
    step(0, 4'b0000, 4'b0100, 4'b0000, 2'b10, 0, 0, "single_release");
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b10, 0, 0, "idle_s_holds");

    // Direct handover with no idle bubble
    step(0, 4'b0011, 4'b0010, 4'b0001, 2'b00, 0, 1, "handover_owner0");
    step(0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1, 1, "handover_owner1");
    step(0, 4'b0000, 4'b0010, 4'b0000, 2'b01, 0, 0, "handover_idle");

    // Round-robin fairness, a=1010
    step(1, 4'b0000, 4'b1010, 4'b0000, 2'b00, 0, 0, "rr_reset");
    step(0, 4'b1111, 4'b1010, 4'b0001, 2'b00, 0, 1, "rr_g0");
    step(0, 4'b1110, 4'b1010, 4'b0010, 2'b01, 1, 1, "rr_g1");
    step(0, 4'b1101, 4'b1010, 4'b0100, 2'b10, 0, 1, "rr_g2");
    step(0, 4'b1011, 4'b1010, 4'b1000, 2'b11, 1, 1, "rr_g3");
    step(0, 4'b0111, 4'b1010, 4'b0001, 2'b00, 0, 1, "rr_g0_wrap");

    // Hold / timeout behaviour with req=1001, a=1000
    step(1, 4'b0000, 4'b1000, 4'b0000, 2'b00, 0, 0, "to_reset");
    for (int i = 0; i < 12; i++) begin
`ifdef MUX_ARB_TIMEOUT_EN
      if (i >= 4 && i < 8)
        step(0, 4'b1001, 4'b1000, 4'b1000, 2'b11, 1, 1, $sformatf("timeout_cyc%0d", i));
      else
        step(0, 4'b1001, 4'b1000, 4'b0001, 2'b00, 0, 1, $sformatf("timeout_cyc%0d", i));
`else
      step(0, 4'b1001, 4'b1000, 4'b0001, 2'b00, 0, 1, $sformatf("hold_cyc%0d", i));
`endif
    end

    // Lone owner keeps grant well past HOLD_MAX (counter saturates)
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "sat_reset");
    for (int i = 0; i < 10; i++)
      step(0, 4'b0001, 4'b0001, 4'b0001, 2'b00, 1, 1, $sformatf("sat_cyc%0d", i));

    // Reset mid-grant, then regrant one cycle after release
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "mid_handover");
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "mid_hold");
    step(1, 4'b0100, 4'b0100, 4'b0000, 2'b00, 0, 0, "mid_reset");
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "mid_regrant");

    // Randomised data while a single owner holds: y must equal a[owner]
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rv;
      rv = 4'($urandom_range(0, 15));
      step(0, 4'b0100, rv, 4'b0100, 2'b10, rv[2], 1, $sformatf("rand_data%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
